// File: rtl/fazyrv_rf_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : fazyrv_rf_ram_bridge
// Purpose  : Serialises 32-bit register-file word requests onto a narrow
//            single-port synchronous SRAM (RAM_DW bits) and reassembles reads.
// Option   : FAZYRV_RF_ZERO_SKIP_EN - accesses to word address 0 issue no beats.
// Revision : 1.0 - initial release
// ============================================================================
module fazyrv_rf_ram_bridge #(
    parameter int ADR_WIDTH = 5,
    parameter int RAM_DW    = 8,
    parameter int DUAL_RD   = 0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_in,
    input  logic                                  ram_we_i,
    input  logic [ADR_WIDTH-1:0]                  ram_waddr_i,
    input  logic [31:0]                           ram_wdata_i,
    input  logic                                  ram_re_i,
    input  logic [ADR_WIDTH-1:0]                  ram_raddr_ab_i,
    input  logic [ADR_WIDTH-1:0]                  ram_raddr_b_i,
    output logic [31:0]                           ram_rdata_ab_o,
    output logic [31:0]                           ram_rdata_b_o,
    output logic                                  rvalid_o,
    output logic                                  busy_o,
    output logic [ADR_WIDTH+$clog2(32/RAM_DW)-1:0] mem_adr_o,
    output logic                                  mem_we_o,
    output logic [RAM_DW-1:0]                     mem_wdata_o,
    input  logic [RAM_DW-1:0]                     mem_rdata_i
);

    localparam int c_N  = 32 / RAM_DW;
    localparam int c_BW = $clog2(c_N);
    localparam int c_CW = (c_BW > 0) ? c_BW : 1;
    localparam int c_AW = ADR_WIDTH + c_BW;

`ifdef FAZYRV_RF_ZERO_SKIP_EN
    localparam bit c_ZERO_SKIP = 1'b1;
`else
    localparam bit c_ZERO_SKIP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_RD_A  = 3'd2,
        S_RD_B  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [c_CW-1:0]        r_cnt, w_cnt_nxt;
    logic [ADR_WIDTH-1:0]   r_waddr, r_raddr_ab, r_raddr_b;
    logic [31:0]            r_wdata;
    logic                   r_rd_pend, r_skip_a, r_skip_b;
    logic                   r_cap_a, r_cap_b;
    logic [31:0]            r_asm_a, r_asm_b, r_rdata_ab, r_rdata_b;
    logic                   r_rvalid, r_busy, r_mem_we;
    logic [c_AW-1:0]        r_mem_adr;
    logic [RAM_DW-1:0]      r_mem_wdata;

    logic                   w_accept, w_last, w_wr_go, w_in_skip_a, w_in_skip_b;
    logic [ADR_WIDTH-1:0]   w_src_waddr, w_src_ab, w_src_b, w_adr_word;
    logic [31:0]            w_src_wdata, w_wdata_sh;
    logic                   w_mem_we_nxt;
    logic [c_AW-1:0]        w_mem_adr_nxt;
    logic [RAM_DW-1:0]      w_mem_wdata_nxt;
    logic [RAM_DW+31:0]     w_cat_a, w_cat_b;
    logic [31:0]            w_sh_a, w_sh_b;

    // First read state after the write phase (or after acceptance), skipping zero-address words
    function automatic state_t f_rd_entry(input logic skip_a, input logic skip_b);
        if (!skip_a)      return S_RD_A;
        else if (!skip_b) return S_RD_B;
        else              return S_DRAIN;
    endfunction

    assign w_accept    = (r_state == S_IDLE) && (ram_we_i || ram_re_i);
    assign w_last      = (r_cnt == c_CW'(c_N - 1));
    assign w_wr_go     = ram_we_i && !(c_ZERO_SKIP && (ram_waddr_i == '0));
    assign w_in_skip_a = c_ZERO_SKIP && (ram_raddr_ab_i == '0);
    assign w_in_skip_b = (DUAL_RD == 0) || (c_ZERO_SKIP && (ram_raddr_b_i == '0));

    // The first beat is registered on the acceptance edge, so IDLE uses the live inputs
    assign w_src_waddr = (r_state == S_IDLE) ? ram_waddr_i    : r_waddr;
    assign w_src_ab    = (r_state == S_IDLE) ? ram_raddr_ab_i : r_raddr_ab;
    assign w_src_b     = (r_state == S_IDLE) ? ram_raddr_b_i  : r_raddr_b;
    assign w_src_wdata = (r_state == S_IDLE) ? ram_wdata_i    : r_wdata;

    assign w_cat_a = {mem_rdata_i, r_asm_a};
    assign w_cat_b = {mem_rdata_i, r_asm_b};
    assign w_sh_a  = w_cat_a[RAM_DW +: 32];
    assign w_sh_b  = w_cat_b[RAM_DW +: 32];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_wr_go)
                    w_state_nxt = S_WR;
                else if (ram_re_i)
                    w_state_nxt = f_rd_entry(w_in_skip_a, w_in_skip_b);
            end
            S_WR: begin
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_rd_pend ? f_rd_entry(r_skip_a, r_skip_b) : S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RD_A: begin
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_skip_b ? S_DRAIN : S_RD_B;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RD_B: begin
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_adr_word = '0;
        case (w_state_nxt)
            S_WR:    w_adr_word = w_src_waddr;
            S_RD_A:  w_adr_word = w_src_ab;
            S_RD_B:  w_adr_word = w_src_b;
            default: w_adr_word = '0;
        endcase
        w_mem_adr_nxt   = (c_AW'(w_adr_word) << c_BW) | c_AW'(w_cnt_nxt);
        w_mem_we_nxt    = (w_state_nxt == S_WR);
        w_wdata_sh      = w_src_wdata >> (int'(w_cnt_nxt) * RAM_DW);
        w_mem_wdata_nxt = w_mem_we_nxt ? w_wdata_sh[RAM_DW-1:0] : '0;
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_waddr     <= '0;
            r_raddr_ab  <= '0;
            r_raddr_b   <= '0;
            r_wdata     <= '0;
            r_rd_pend   <= 1'b0;
            r_skip_a    <= 1'b0;
            r_skip_b    <= 1'b0;
            r_cap_a     <= 1'b0;
            r_cap_b     <= 1'b0;
            r_asm_a     <= '0;
            r_asm_b     <= '0;
            r_rdata_ab  <= '0;
            r_rdata_b   <= '0;
            r_rvalid    <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_adr   <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_mem_we    <= w_mem_we_nxt;
            r_mem_adr   <= w_mem_adr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            // SRAM data lags the address by one cycle
            r_cap_a     <= (r_state == S_RD_A);
            r_cap_b     <= (r_state == S_RD_B);
            r_rvalid    <= (r_state == S_DRAIN);

            if (w_accept) begin
                r_waddr    <= ram_waddr_i;
                r_wdata    <= ram_wdata_i;
                r_raddr_ab <= ram_raddr_ab_i;
                r_raddr_b  <= ram_raddr_b_i;
                r_rd_pend  <= ram_re_i;
                r_skip_a   <= w_in_skip_a;
                r_skip_b   <= w_in_skip_b;
                if (ram_re_i) begin
                    r_asm_a <= '0;
                    r_asm_b <= '0;
                end
            end else begin
                if (r_cap_a) r_asm_a <= w_sh_a;
                if (r_cap_b) r_asm_b <= w_sh_b;
            end

            if (r_state == S_DRAIN) begin
                r_rdata_ab <= r_cap_a ? w_sh_a : r_asm_a;
                r_rdata_b  <= r_cap_b ? w_sh_b : r_asm_b;
            end
        end
    end

    assign ram_rdata_ab_o = r_rdata_ab;
    assign ram_rdata_b_o  = r_rdata_b;
    assign rvalid_o       = r_rvalid;
    assign busy_o         = r_busy;
    assign mem_adr_o      = r_mem_adr;
    assign mem_we_o       = r_mem_we;
    assign mem_wdata_o    = r_mem_wdata;

endmodule
`default_nettype wire

// File: doc/fazyrv_rf_ram_bridge.md
Name: fazyrv_rf_ram_bridge

Overview:
- Sits directly downstream of the register-file buffer stage.
- Accepts its 32-bit word RAM requests (write port plus one or two read addresses) and serialises them onto a narrow single-port synchronous SRAM of width RAM_DW.
- Reassembles read words LSB-beat-first and signals completion.
- Lets FazyRV use narrow latch/SRAM macros instead of 32-bit-wide BRAM.

Parameters:
- ADR_WIDTH, 5, word address width of the register/CSR space.
- RAM_DW, 8, physical SRAM data width; legal values 8, 16, 32. N = 32/RAM_DW beats per word; BW = log2(N).
- DUAL_RD, 0, 1 = each read request fetches both ab and b words; 0 = ab only, b output held at 0.

Ports:
- clk_i  in  1  clock, rising edge
- rst_in  in  1  asynchronous reset, active low
- ram_we_i  in  1  word write request
- ram_waddr_i  in  ADR_WIDTH  write word address
- ram_wdata_i  in  32  write data
- ram_re_i  in  1  word read request
- ram_raddr_ab_i  in  ADR_WIDTH  read address ab
- ram_raddr_b_i  in  ADR_WIDTH  read address b (used only if DUAL_RD=1)
- ram_rdata_ab_o  out  32  assembled word ab, registered
- ram_rdata_b_o  out  32  assembled word b, registered
- rvalid_o  out  1  one-cycle pulse when read data is complete
- busy_o  out  1  high while not in IDLE; requests are ignored while high
- mem_adr_o  out  ADR_WIDTH+BW  physical address {word_addr, beat}
- mem_we_o  out  1  physical write enable
- mem_wdata_o  out  RAM_DW  physical write data
- mem_rdata_i  in  RAM_DW  physical read data, valid the cycle after the address

Behaviour:
- Reset (async, rst_in=0): FSM goes to IDLE, beat counter 0. Outputs: ram_rdata_ab_o=0, ram_rdata_b_o=0, rvalid_o=0, busy_o=0, mem_we_o=0, mem_adr_o=0, mem_wdata_o=0. Reset mid-transfer aborts it immediately; a partial SRAM write is acceptable and no rvalid_o is produced.
- FSM states:
  - IDLE
  - WR: N cycles
  - RD_A: N cycles
  - RD_B: N cycles, DUAL_RD only
  - DRAIN: 1 cycle
- IDLE, request accepted on a rising edge with busy_o=0:
  - Capture waddr, wdata, raddr_ab, raddr_b, a write-pending flag and a read-pending flag.
  - Next state: WR if we_i; else RD_A if re_i; else stay IDLE.
  - Simultaneous we_i and re_i: write executes first, then the read. The read therefore sees the new data if the addresses match.
- WR, beat k = 0..N-1:
  - mem_we_o=1, mem_adr_o={waddr_r,k}, mem_wdata_o=wdata_r[k*RAM_DW +: RAM_DW].
  - After beat N-1: go to RD_A if read pending, else IDLE.
  - Write latency: busy for exactly N cycles after acceptance.
- RD_A / RD_B, beat k:
  - mem_we_o=0, mem_adr_o={addr_r,k}.
  - Data of each beat arrives one cycle later and is shifted into an assembly register from the MSB side, so beat 0 lands in bits [RAM_DW-1:0].
  - RD_A last beat: go to RD_B if DUAL_RD, else DRAIN.
  - RD_B last beat: go to DRAIN.
  - RD_A to RD_B is back-to-back with no bubble; the first b beat is issued while the last a beat returns.
- DRAIN:
  - Capture the final beat.
  - Load the assembly registers into ram_rdata_*_o at the end of the cycle.
  - Go to IDLE; rvalid_o=1 in the following cycle.
- Read latency: with acceptance edge at cycle T, rvalid_o is high in cycle T+N+2 (single read) or T+2N+2 (DUAL_RD). Add N if a write was co-accepted.
- busy_o is already 0 in the rvalid_o cycle, so a new request may be accepted on that edge.
- ram_rdata_*_o hold their value until the next read completes.
- Counter wrap: beat counter is BW bits wide and wraps to 0 at the end of every state.
- With RAM_DW=32 (N=1), the FSM still passes through every state; no special-casing.
- No address filtering: address 0 protection stays upstream, and the bridge writes whatever it is given.

Optional Feature:
- Macro: FAZYRV_RF_ZERO_SKIP_EN.
- Defined: a read of word address 0 issues no SRAM beats.
  - DUAL_RD=0: for ab=0, go IDLE->DRAIN directly, giving rvalid_o at T+2 with ram_rdata_ab_o=0.
  - DUAL_RD=1: each zero address skips its own N beats and its word returns 0. If both addresses are 0, rvalid_o is at T+2.
  - Writes to address 0 are also dropped: no WR beats, and busy_o stays low if no read is pending.
- Undefined: address 0 is treated like any other address.

Test Plan (RAM_DW=8, N=4, ADR_WIDTH=5):
- Write 0xDEADBEEF to addr 3 -> mem_we_o high 4 cycles; mem_adr_o=12,13,14,15; mem_wdata_o=EF,BE,AD,DE; busy_o low after 4 cycles.
- Read ab=3 after that write -> rvalid_o at T+6, ram_rdata_ab_o=0xDEADBEEF, mem_we_o stays 0.
- DUAL_RD=1: preload 5=0x01234567, 7=0x89ABCDEF; read ab=5, b=7 -> rvalid_o at T+10; outputs 0x01234567 / 0x89ABCDEF.
- Simultaneous we (addr 9, 0xCAFEF00D) and re (ab=9) -> 4 write beats then read; rvalid_o at T+10; data 0xCAFEF00D.
- Pull rst_in low in the 2nd RD_A beat -> all outputs 0 immediately, no rvalid_o; a new read after release returns correct data.
- FAZYRV_RF_ZERO_SKIP_EN defined, read ab=0 -> no mem_adr_o activity, rvalid_o at T+2, data 0. Undefined: 4 beats issued at mem_adr_o=0..3.
